// File: rtl/apb2axi_pkg.sv
// apb2axi_pkg: shared AXI response codes, burst types, burst context and FSM states
package apb2axi_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // Context fields are sized for the widest supported address/ID; users slice down
    localparam int unsigned CTX_ADDR_W = 64;
    localparam int unsigned CTX_ID_W   = 16;

    typedef enum logic [1:0] {
        BURST_FIXED = 2'b00,
        BURST_INCR  = 2'b01,
        BURST_WRAP  = 2'b10,
        BURST_RSVD  = 2'b11
    } burst_t;

    typedef struct packed {
        logic [CTX_ID_W-1:0]   id;
        logic [CTX_ADDR_W-1:0] addr;
        logic [3:0]            len;
        logic [2:0]            size;
        burst_t                burst;
        logic [3:0]            beat;
    } axi_burst_ctx_t;

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wr_state_t;
    typedef enum logic {R_IDLE, R_DATA} rd_state_t;

    function automatic logic burst_illegal(burst_t b);
        return b == BURST_WRAP || b == BURST_RSVD;
    endfunction

endpackage

// File: rtl/apb2axi_axi_addr_gen.sv
// apb2axi_axi_addr_gen: word index, legality check and next-beat address for one burst beat
module apb2axi_axi_addr_gen
    import apb2axi_pkg::*;
#(
    parameter int unsigned           AXI_ADDR_W = 32,
    parameter int unsigned           AXI_DATA_W = 64,
    parameter int unsigned           MEM_DEPTH  = 256,
    parameter logic [AXI_ADDR_W-1:0] BASE_ADDR  = '0,
    parameter int unsigned           IDX_W      = MEM_DEPTH > 1 ? $clog2(MEM_DEPTH) : 1
) (
    input  logic [AXI_ADDR_W-1:0] addr,
    input  logic [2:0]            size,
    input  burst_t                burst,
    output logic [AXI_ADDR_W-1:0] next_addr,
    output logic [IDX_W-1:0]      idx,
    output logic                  err
);

    localparam int unsigned LANE_SH = $clog2(AXI_DATA_W / 8);

    logic                  below;
    logic [AXI_ADDR_W-1:0] off;
    logic [AXI_ADDR_W-1:0] word;

    // The borrow of addr - BASE_ADDR flags accesses below the base without a constant compare
    always_comb begin
        {below, off} = {1'b0, addr} - {1'b0, BASE_ADDR};
        word         = off >> LANE_SH;
        idx          = word[IDX_W-1:0];
        err          = below || word >= AXI_ADDR_W'(MEM_DEPTH) || size > 3'(LANE_SH) || burst_illegal(burst);
        next_addr    = burst == BURST_FIXED ? addr : addr + (AXI_ADDR_W'(1) << size);
    end

endmodule

// File: rtl/apb2axi_axi_mem_slave.sv
// apb2axi_axi_mem_slave: AXI3 memory end-point with independent single-burst write and read FSMs
module apb2axi_axi_mem_slave
    import apb2axi_pkg::*;
#(
    parameter int unsigned           AXI_ADDR_W = 32,
    parameter int unsigned           AXI_DATA_W = 64,
    parameter int unsigned           AXI_ID_W   = 4,
    parameter int unsigned           MEM_DEPTH  = 256,
    parameter logic [AXI_ADDR_W-1:0] BASE_ADDR  = '0
) (
    input  logic                    ACLK,
    input  logic                    ARESET,
    input  logic [AXI_ID_W-1:0]     AWID,
    input  logic [AXI_ADDR_W-1:0]   AWADDR,
    input  logic [3:0]              AWLEN,
    input  logic [2:0]              AWSIZE,
    input  logic [1:0]              AWBURST,
    input  logic [1:0]              AWLOCK,
    input  logic [3:0]              AWCACHE,
    input  logic [2:0]              AWPROT,
    input  logic                    AWVALID,
    output logic                    AWREADY,
    input  logic [AXI_DATA_W-1:0]   WDATA,
    input  logic [AXI_DATA_W/8-1:0] WSTRB,
    input  logic                    WLAST,
    input  logic                    WVALID,
    output logic                    WREADY,
    output logic [AXI_ID_W-1:0]     BID,
    output logic [1:0]              BRESP,
    output logic                    BVALID,
    input  logic                    BREADY,
    input  logic [AXI_ID_W-1:0]     ARID,
    input  logic [AXI_ADDR_W-1:0]   ARADDR,
    input  logic [3:0]              ARLEN,
    input  logic [2:0]              ARSIZE,
    input  logic [1:0]              ARBURST,
    input  logic [1:0]              ARLOCK,
    input  logic [3:0]              ARCACHE,
    input  logic [2:0]              ARPROT,
    input  logic                    ARVALID,
    output logic                    ARREADY,
    output logic [AXI_ID_W-1:0]     RID,
    output logic [AXI_DATA_W-1:0]   RDATA,
    output logic [1:0]              RRESP,
    output logic                    RLAST,
    output logic                    RVALID,
    input  logic                    RREADY
);

    localparam int unsigned STRB_W = AXI_DATA_W / 8;
    localparam int unsigned IDX_W  = MEM_DEPTH > 1 ? $clog2(MEM_DEPTH) : 1;

    logic [AXI_DATA_W-1:0] mem [MEM_DEPTH];

    wr_state_t             w_state;
    axi_burst_ctx_t        w_ctx;
    logic                  w_err;
    logic [AXI_ADDR_W-1:0] w_cur;
    logic [AXI_ADDR_W-1:0] w_next;
    logic [IDX_W-1:0]      w_idx;
    logic                  w_beat_err;
    logic                  w_hs;
    logic                  w_last_beat;
    logic                  w_err_next;

    rd_state_t             r_state;
    axi_burst_ctx_t        r_ctx;
    logic [AXI_ADDR_W-1:0] r_cur;
    logic [2:0]            r_size;
    burst_t                r_burst;
    logic [AXI_ADDR_W-1:0] r_next;
    logic [IDX_W-1:0]      r_idx;
    logic                  r_beat_err;
    logic [AXI_DATA_W-1:0] r_word;
    logic [1:0]            r_resp;
    logic                  r_last_beat;

    logic unused;
    assign unused = ^{AWLOCK, AWCACHE, AWPROT, ARLOCK, ARCACHE, ARPROT, w_ctx, r_ctx};

    assign w_cur       = w_ctx.addr[AXI_ADDR_W-1:0];
    assign w_hs        = WVALID && WREADY;
    assign w_last_beat = w_ctx.beat == w_ctx.len;
    assign w_err_next  = w_err || w_beat_err || (WLAST != w_last_beat);

    apb2axi_axi_addr_gen #(
        .AXI_ADDR_W(AXI_ADDR_W),
        .AXI_DATA_W(AXI_DATA_W),
        .MEM_DEPTH (MEM_DEPTH),
        .BASE_ADDR (BASE_ADDR),
        .IDX_W     (IDX_W)
    ) u_wgen (
        .addr     (w_cur),
        .size     (w_ctx.size),
        .burst    (w_ctx.burst),
        .next_addr(w_next),
        .idx      (w_idx),
        .err      (w_beat_err)
    );

    // In idle the read generator looks at the incoming AR so beat 0 is fetched on capture;
    // afterwards r_ctx.addr already holds the address of the next beat to fetch
    assign r_cur       = r_state == R_IDLE ? ARADDR : r_ctx.addr[AXI_ADDR_W-1:0];
    assign r_size      = r_state == R_IDLE ? ARSIZE : r_ctx.size;
    assign r_burst     = r_state == R_IDLE ? burst_t'(ARBURST) : r_ctx.burst;
    assign r_word      = r_beat_err ? '0 : mem[r_idx];
    assign r_resp      = r_beat_err ? RESP_SLVERR : RESP_OKAY;
    assign r_last_beat = r_ctx.beat == r_ctx.len;

    apb2axi_axi_addr_gen #(
        .AXI_ADDR_W(AXI_ADDR_W),
        .AXI_DATA_W(AXI_DATA_W),
        .MEM_DEPTH (MEM_DEPTH),
        .BASE_ADDR (BASE_ADDR),
        .IDX_W     (IDX_W)
    ) u_rgen (
        .addr     (r_cur),
        .size     (r_size),
        .burst    (r_burst),
        .next_addr(r_next),
        .idx      (r_idx),
        .err      (r_beat_err)
    );

    // Byte-lane writes for accepted in-range beats; contents survive reset
    always_ff @(posedge ACLK) begin
        if (w_hs && !w_beat_err)
            for (int b = 0; b < STRB_W; b++)
                if (WSTRB[b]) mem[w_idx][8*b +: 8] <= WDATA[8*b +: 8];
    end

    // Write FSM: accept AW, take len+1 beats regardless of WLAST, then hold the B response
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            w_state <= W_IDLE;
            w_ctx   <= '0;
            w_err   <= 1'b0;
            AWREADY <= 1'b1;
            WREADY  <= 1'b0;
            BVALID  <= 1'b0;
            BID     <= '0;
            BRESP   <= RESP_OKAY;
        end else begin
            case (w_state)
                W_IDLE: if (AWVALID) begin
                    w_ctx   <= '{id: CTX_ID_W'(AWID), addr: CTX_ADDR_W'(AWADDR), len: AWLEN,
                                 size: AWSIZE, burst: burst_t'(AWBURST), beat: 4'd0};
                    w_err   <= 1'b0;
                    AWREADY <= 1'b0;
                    WREADY  <= 1'b1;
                    w_state <= W_DATA;
                end
                W_DATA: if (WVALID) begin
                    w_ctx.addr <= CTX_ADDR_W'(w_next);
                    w_ctx.beat <= w_ctx.beat + 4'd1;
                    w_err      <= w_err_next;
                    if (w_last_beat) begin
                        WREADY  <= 1'b0;
                        BVALID  <= 1'b1;
                        BID     <= w_ctx.id[AXI_ID_W-1:0];
                        BRESP   <= w_err_next ? RESP_SLVERR : RESP_OKAY;
                        w_state <= W_RESP;
                    end
                end
                W_RESP: if (BREADY) begin
                    BVALID  <= 1'b0;
                    AWREADY <= 1'b1;
                    w_state <= W_IDLE;
                end
                default: w_state <= W_IDLE;
            endcase
        end
    end

    // Read FSM: capture AR with beat 0 registered, then fetch one beat per R handshake
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            r_state <= R_IDLE;
            r_ctx   <= '0;
            ARREADY <= 1'b1;
            RVALID  <= 1'b0;
            RLAST   <= 1'b0;
            RID     <= '0;
            RDATA   <= '0;
            RRESP   <= RESP_OKAY;
        end else begin
            case (r_state)
                R_IDLE: if (ARVALID) begin
                    r_ctx   <= '{id: CTX_ID_W'(ARID), addr: CTX_ADDR_W'(r_next), len: ARLEN,
                                 size: ARSIZE, burst: burst_t'(ARBURST), beat: 4'd0};
                    ARREADY <= 1'b0;
                    RVALID  <= 1'b1;
                    RLAST   <= ARLEN == 4'd0;
                    RID     <= ARID;
                    RDATA   <= r_word;
                    RRESP   <= r_resp;
                    r_state <= R_DATA;
                end
                R_DATA: if (RREADY) begin
                    if (r_last_beat) begin
                        RVALID  <= 1'b0;
                        RLAST   <= 1'b0;
                        ARREADY <= 1'b1;
                        r_state <= R_IDLE;
                    end else begin
                        r_ctx.addr <= CTX_ADDR_W'(r_next);
                        r_ctx.beat <= r_ctx.beat + 4'd1;
                        RLAST      <= r_ctx.beat + 4'd1 == r_ctx.len;
                        RDATA      <= r_word;
                        RRESP      <= r_resp;
                    end
                end
                default: r_state <= R_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_apb2axi_axi_mem_slave.sv
// tb_apb2axi_axi_mem_slave: table, directed and random AXI traffic against a byte-level memory model
module tb_apb2axi_axi_mem_slave;

    localparam logic [1:0] OKAY = 2'b00, SLVERR = 2'b10;
    localparam logic [1:0] FIXED = 2'b00, INCR = 2'b01, WRAP = 2'b10;

    logic        ACLK = 1'b0, ARESET = 1'b1;
    logic [3:0]  AWID = '0, ARID = '0, BID, RID;
    logic [31:0] AWADDR = '0, ARADDR = '0;
    logic [3:0]  AWLEN = '0, ARLEN = '0;
    logic [2:0]  AWSIZE = '0, ARSIZE = '0;
    logic [1:0]  AWBURST = '0, ARBURST = '0, BRESP, RRESP;
    logic        AWVALID = 1'b0, ARVALID = 1'b0, WVALID = 1'b0, WLAST = 1'b0, BREADY = 1'b0, RREADY = 1'b0;
    logic        AWREADY, ARREADY, WREADY, BVALID, RVALID, RLAST;
    logic [63:0] WDATA = '0, RDATA;
    logic [7:0]  WSTRB = '0;

    apb2axi_axi_mem_slave dut (
        .ACLK(ACLK), .ARESET(ARESET),
        .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWBURST(AWBURST),
        .AWLOCK(2'b00), .AWCACHE(4'h0), .AWPROT(3'h0), .AWVALID(AWVALID), .AWREADY(AWREADY),
        .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
        .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
        .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARBURST(ARBURST),
        .ARLOCK(2'b00), .ARCACHE(4'h0), .ARPROT(3'h0), .ARVALID(ARVALID), .ARREADY(ARREADY),
        .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY)
    );

    always #5 ACLK = ~ACLK;

    int total = 0, bad = 0;
    logic [63:0] model [256];
    logic [63:0] wbuf [16];
    logic [7:0]  sbuf [16];
    logic [63:0] rbuf [16];
    logic [1:0]  rrbuf [16];
    logic        rlbuf [16];

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  len;
        logic [2:0]  size;
        logic [1:0]  burst;
        logic [7:0]  strb;
        logic [1:0]  exp_b;
        logic [1:0]  exp_r0;
    } vec_t;
    vec_t vt [10];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        total++;
        bad++;
        $display("FAIL %s: timed out", name);
    endtask

    function automatic logic [31:0] beat_addr(logic [31:0] a, logic [2:0] sz, logic [1:0] bu, int k);
        return bu == FIXED ? a : a + 32'(k) * (32'd1 << sz);
    endfunction

    function automatic bit beat_bad(logic [31:0] a, logic [2:0] sz, logic [1:0] bu);
        return (a >> 3) >= 32'd256 || sz > 3'd3 || bu[1];
    endfunction

    task automatic do_write(input logic [3:0] id, input logic [31:0] a, input logic [3:0] len,
                            input logic [2:0] sz, input logic [1:0] bu, input bit bad_last,
                            output logic [1:0] resp);
        int n;
        bit any_bad;
        logic [31:0] ak;
        @(negedge ACLK);
        AWID = id; AWADDR = a; AWLEN = len; AWSIZE = sz; AWBURST = bu; AWVALID = 1'b1;
        n = 0;
        while (!AWREADY && n < 200) begin @(negedge ACLK); n++; end
        if (n == 200) timeout("aw_handshake");
        @(negedge ACLK);
        AWVALID = 1'b0;
        check("wready_after_aw", WREADY, 1);
        for (int k = 0; k <= int'(len); k++) begin
            WDATA = wbuf[k]; WSTRB = sbuf[k]; WVALID = 1'b1;
            WLAST = bad_last ? (k != int'(len)) : (k == int'(len));
            n = 0;
            while (!WREADY && n < 200) begin @(negedge ACLK); n++; end
            if (n == 200) timeout("w_handshake");
            @(negedge ACLK);
        end
        WVALID = 1'b0; WLAST = 1'b0;
        check("bvalid_after_last_w", BVALID, 1);
        BREADY = 1'b1;
        n = 0;
        while (!BVALID && n < 200) begin @(negedge ACLK); n++; end
        if (n == 200) timeout("b_handshake");
        resp = BRESP;
        check("bid", BID, id);
        @(negedge ACLK);
        BREADY = 1'b0;
        check("awready_after_b", AWREADY, 1);
        any_bad = bad_last;
        for (int k = 0; k <= int'(len); k++) begin
            ak = beat_addr(a, sz, bu, k);
            if (beat_bad(ak, sz, bu)) any_bad = 1;
            else for (int b = 0; b < 8; b++) if (sbuf[k][b]) model[ak[10:3]][8*b +: 8] = wbuf[k][8*b +: 8];
        end
        check("bresp_model", resp, any_bad ? SLVERR : OKAY);
    endtask

    task automatic do_read(input logic [3:0] id, input logic [31:0] a, input logic [3:0] len,
                           input logic [2:0] sz, input logic [1:0] bu, input bit rnd_ready);
        int n, k;
        bit stalled, bb;
        logic [63:0] held;
        logic [31:0] ak;
        @(negedge ACLK);
        ARID = id; ARADDR = a; ARLEN = len; ARSIZE = sz; ARBURST = bu; ARVALID = 1'b1;
        n = 0;
        while (!ARREADY && n < 200) begin @(negedge ACLK); n++; end
        if (n == 200) timeout("ar_handshake");
        @(negedge ACLK);
        ARVALID = 1'b0;
        check("rvalid_after_ar", RVALID, 1);
        k = 0; n = 0; stalled = 0; held = '0;
        while (k <= int'(len) && n < 1000) begin
            if (stalled) check("rdata_stable_stall", RDATA, held);
            RREADY = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            if (RVALID && RREADY) begin
                ak = beat_addr(a, sz, bu, k);
                bb = beat_bad(ak, sz, bu);
                rbuf[k] = RDATA; rrbuf[k] = RRESP; rlbuf[k] = RLAST;
                check("rdata_model", RDATA, bb ? 64'h0 : model[ak[10:3]]);
                check("rresp_model", RRESP, bb ? SLVERR : OKAY);
                check("rlast", RLAST, k == int'(len));
                check("rid", RID, id);
                k++;
                stalled = 0;
            end else begin
                stalled = RVALID;
                held = RDATA;
            end
            @(negedge ACLK);
            n++;
        end
        RREADY = 1'b0;
        if (k <= int'(len)) timeout("r_beats");
        check("arready_after_last_r", ARREADY, 1);
    endtask

    initial begin
        logic [1:0]  resp;
        logic [31:0] a;
        vt[0] = '{32'h10,       4'd0,  3'd3, INCR,  8'hFF, OKAY,   OKAY};
        vt[1] = '{32'h00,       4'd3,  3'd3, INCR,  8'hFF, OKAY,   OKAY};
        vt[2] = '{32'h40,       4'd2,  3'd3, FIXED, 8'hFF, OKAY,   OKAY};
        vt[3] = '{32'h80,       4'd1,  3'd2, INCR,  8'h0F, OKAY,   OKAY};
        vt[4] = '{32'h7F8,      4'd1,  3'd3, INCR,  8'hFF, SLVERR, OKAY};
        vt[5] = '{32'h800,      4'd1,  3'd3, INCR,  8'hFF, SLVERR, SLVERR};
        vt[6] = '{32'h20,       4'd1,  3'd3, WRAP,  8'hFF, SLVERR, SLVERR};
        vt[7] = '{32'h20,       4'd0,  3'd4, INCR,  8'hFF, SLVERR, SLVERR};
        vt[8] = '{32'h300,      4'd15, 3'd3, INCR,  8'hA5, OKAY,   OKAY};
        vt[9] = '{32'hFFFFFFF8, 4'd1,  3'd3, INCR,  8'hFF, SLVERR, SLVERR};

        // reset values
        repeat (2) @(negedge ACLK);
        check("rst_awready", AWREADY, 1);
        check("rst_arready", ARREADY, 1);
        check("rst_wready", WREADY, 0);
        check("rst_bvalid", BVALID, 0);
        check("rst_rvalid", RVALID, 0);
        check("rst_rlast", RLAST, 0);
        check("rst_bid_bresp", {BID, BRESP}, 0);
        check("rst_rid_rresp", {RID, RRESP}, 0);
        check("rst_rdata", RDATA, 0);
        ARESET = 1'b0;

        // W presented before any AW is stalled
        @(negedge ACLK);
        WVALID = 1'b1;
        repeat (3) begin @(negedge ACLK); check("w_stall_before_aw", WREADY, 0); end
        WVALID = 1'b0;

        // preload every word so the model is fully known
        for (int blk = 0; blk < 16; blk++) begin
            for (int k = 0; k < 16; k++) begin wbuf[k] = {$urandom, $urandom}; sbuf[k] = 8'hFF; end
            do_write(4'(blk), 32'(blk * 128), 4'd15, 3'd3, INCR, 0, resp);
        end

        // single write and read-back
        wbuf[0] = 64'hDEADBEEF_CAFEF00D; sbuf[0] = 8'hFF;
        do_write(4'h3, 32'h10, 4'd0, 3'd3, INCR, 0, resp);
        check("single_bresp", resp, OKAY);
        do_read(4'h5, 32'h10, 4'd0, 3'd3, INCR, 0);
        check("single_rdata", rbuf[0], 64'hDEADBEEF_CAFEF00D);
        check("single_rlast", rlbuf[0], 1);

        // WRAP write is rejected and leaves memory alone
        wbuf[0] = 64'h0; wbuf[1] = 64'h0;
        do_write(4'h1, 32'h10, 4'd1, 3'd3, WRAP, 0, resp);
        check("wrap_bresp", resp, SLVERR);
        do_read(4'h1, 32'h10, 4'd0, 3'd3, INCR, 0);
        check("wrap_unchanged", rbuf[0], 64'hDEADBEEF_CAFEF00D);

        // INCR burst of 1..4
        for (int k = 0; k < 4; k++) begin wbuf[k] = 64'(k + 1); sbuf[k] = 8'hFF; end
        do_write(4'h2, 32'h0, 4'd3, 3'd3, INCR, 0, resp);
        do_read(4'h2, 32'h0, 4'd3, 3'd3, INCR, 0);
        for (int k = 0; k < 4; k++) begin
            check("incr_data", rbuf[k], 64'(k + 1));
            check("incr_rlast", rlbuf[k], k == 3);
            check("incr_rresp", rrbuf[k], OKAY);
        end

        // partial strobe
        wbuf[0] = '1; sbuf[0] = 8'hFF;
        do_write(4'h4, 32'h50, 4'd0, 3'd3, INCR, 0, resp);
        wbuf[0] = '0; sbuf[0] = 8'h0F;
        do_write(4'h4, 32'h50, 4'd0, 3'd3, INCR, 0, resp);
        do_read(4'h4, 32'h50, 4'd0, 3'd3, INCR, 0);
        check("partial_strobe", rbuf[0], 64'hFFFFFFFF_00000000);

        // out-of-range read
        do_read(4'h6, 32'h800, 4'd1, 3'd3, INCR, 0);
        for (int k = 0; k < 2; k++) begin
            check("oor_rdata", rbuf[k], 0);
            check("oor_rresp", rrbuf[k], SLVERR);
        end

        // WLAST mismatch errors the response but still writes the data
        wbuf[0] = 64'h1111; wbuf[1] = 64'h2222; sbuf[0] = 8'hFF; sbuf[1] = 8'hFF;
        do_write(4'h7, 32'h60, 4'd1, 3'd3, INCR, 1, resp);
        check("wlast_mismatch_bresp", resp, SLVERR);
        do_read(4'h7, 32'h60, 4'd1, 3'd3, INCR, 0);

        // table vectors
        for (int i = 0; i < 10; i++) begin
            for (int k = 0; k < 16; k++) begin wbuf[k] = {$urandom, $urandom}; sbuf[k] = vt[i].strb; end
            do_write(4'(i), vt[i].addr, vt[i].len, vt[i].size, vt[i].burst, 0, resp);
            check("vec_bresp", resp, vt[i].exp_b);
            do_read(4'(i), vt[i].addr, vt[i].len, vt[i].size, vt[i].burst, 0);
            check("vec_rresp0", rrbuf[0], vt[i].exp_r0);
        end

        // random traffic
        for (int i = 0; i < 25; i++) begin
            logic [3:0] len;
            logic [2:0] sz;
            logic [1:0] bu;
            a   = $urandom_range(0, 32'h900);
            len = 4'($urandom_range(0, 15));
            sz  = 3'($urandom_range(0, 4));
            bu  = 2'($urandom_range(0, 2));
            for (int k = 0; k < 16; k++) begin wbuf[k] = {$urandom, $urandom}; sbuf[k] = 8'($urandom); end
            do_write(4'($urandom), a, len, sz, bu, $urandom_range(0, 7) == 0, resp);
            do_read(4'($urandom), a, len, sz, bu, 1);
        end

        // concurrent 16-beat write and backpressured 16-beat read on disjoint ranges
        for (int k = 0; k < 16; k++) begin wbuf[k] = {$urandom, $urandom}; sbuf[k] = 8'hFF; end
        fork
            do_write(4'hA, 32'h400, 4'd15, 3'd3, INCR, 0, resp);
            do_read(4'hB, 32'h0, 4'd15, 3'd3, INCR, 1);
        join
        check("concurrent_bresp", resp, OKAY);
        do_read(4'hC, 32'h400, 4'd15, 3'd3, INCR, 0);

        // reset in the middle of a 4-beat write
        @(negedge ACLK);
        AWID = 4'h9; AWADDR = 32'h100; AWLEN = 4'd3; AWSIZE = 3'd3; AWBURST = INCR; AWVALID = 1'b1;
        @(negedge ACLK);
        AWVALID = 1'b0;
        for (int k = 0; k < 2; k++) begin
            WDATA = {$urandom, $urandom}; WSTRB = 8'hFF; WLAST = 1'b0; WVALID = 1'b1;
            model[32 + k] = WDATA;
            @(negedge ACLK);
        end
        WVALID = 1'b0;
        ARESET = 1'b1;
        @(negedge ACLK);
        ARESET = 1'b0;
        check("midrst_wready", WREADY, 0);
        check("midrst_awready", AWREADY, 1);
        check("midrst_bvalid", BVALID, 0);
        @(negedge ACLK);
        check("midrst_no_bvalid", BVALID, 0);
        do_read(4'hD, 32'h100, 4'd3, 3'd3, INCR, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
